// File: rtl/mult_fu_ctrl.sv
// mult_fu_ctrl -- issue controller / result buffer for the shared pipelined
// 64-bit multiplier (low 64 bits of the product).
//
// Requesters are arbitrated round-robin. The granted operands are registered
// onto the multiplier. A tag/valid shadow pipeline follows each op through the
// multiplier. Finished results are queued in a circular output FIFO until the
// CDB takes them. The multiplier cannot stall, so an op is only accepted while
// a credit is free. Every op in flight therefore already owns a FIFO slot.
//
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   req_valid/opa/opb/tag   per-requester issue request
//   req_ready               one-hot grant (combinational, independent of cdb_grant)
//   squash                  flush all in-flight and buffered work
//   mult_start/mcand/mplier issue to multiplier (registered)
//   mult_done/mult_product  multiplier output, STAGES cycles after mult_start
//   cdb_valid/tag/value     output FIFO head
//   cdb_grant               CDB consumes the head this cycle
//   busy                    any credit in use

`ifndef MULT_STAGES
`define MULT_STAGES 8
`endif

module mult_fu_ctrl #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_W     = 6,
    parameter int STAGES    = `MULT_STAGES,
    parameter int OUT_DEPTH = 12
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][63:0]        req_opa,
    input  logic [NUM_REQ-1:0][63:0]        req_opb,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            squash,
    output logic                            mult_start,
    output logic [63:0]                     mult_mcand,
    output logic [63:0]                     mult_mplier,
    input  logic                            mult_done,
    input  logic [63:0]                     mult_product,
    output logic                            cdb_valid,
    output logic [TAG_W-1:0]                cdb_tag,
    output logic [63:0]                     cdb_value,
    input  logic                            cdb_grant,
    output logic                            busy
);
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic [RW-1:0]              rr_ptr_q, rr_ptr_d, gnt_idx, idx;
    logic                       can_issue, accept, push, pop;
    logic [CW-1:0]              credits_q, credits_d, count_q;
    // index 0 is the issue register (same cycle as mult_start); index STAGES
    // lines up with mult_done
    logic [STAGES:0]            vld_pipe_q;
    logic [STAGES:0][TAG_W-1:0] tag_pipe_q;
    logic [63:0]                mcand_q, mplier_q;
    logic [TAG_W-1:0]           fifo_tag_q [OUT_DEPTH];
    logic [63:0]                fifo_val_q [OUT_DEPTH];
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;

    // ---------------- arbitration ----------------
    always_comb begin
        can_issue = !squash && !reset && (credits_q < CW'(OUT_DEPTH));
        gnt_idx   = '0;
        idx       = '0;
        // scan offsets high to low so the nearest valid requester at or above
        // rr_ptr is the last one written
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = RW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[idx]) gnt_idx = idx;
        end
        req_ready = '0;
        if (can_issue && (|req_valid)) req_ready[gnt_idx] = 1'b1;
        accept   = |(req_ready & req_valid);
        rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + RW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)       rr_ptr_q <= '0;
        else if (accept) rr_ptr_q <= rr_ptr_d;
    end

    // ---------------- issue register + shadow pipeline ----------------
    always_ff @(posedge clock) begin
        if (reset || squash) vld_pipe_q <= '0;
        else                 vld_pipe_q <= {vld_pipe_q[STAGES-1:0], accept};
        tag_pipe_q <= {tag_pipe_q[STAGES-1:0], req_tag[gnt_idx]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (accept) begin
            mcand_q  <= req_opa[gnt_idx];
            mplier_q <= req_opb[gnt_idx];
        end
    end

    assign mult_start  = vld_pipe_q[0];
    assign mult_mcand  = mcand_q;
    assign mult_mplier = mplier_q;

    // ---------------- output FIFO ----------------
    // mult_done is not used as a qualifier; the shadow valid is authoritative
    // so results of squashed ops drop out here.
    assign push = vld_pipe_q[STAGES];
    assign pop  = cdb_valid && cdb_grant;

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_tag_q[wr_ptr_q] <= tag_pipe_q[STAGES];
                fifo_val_q[wr_ptr_q] <= mult_product;
                wr_ptr_q <= (wr_ptr_q == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign cdb_valid = (count_q != '0);
    assign cdb_tag   = cdb_valid ? fifo_tag_q[rd_ptr_q] : '0;
    assign cdb_value = cdb_valid ? fifo_val_q[rd_ptr_q] : '0;

    // ---------------- credits ----------------
    // a pop frees its credit only from the next cycle, because can_issue
    // reads the registered count
    assign credits_d = credits_q + CW'(accept) - CW'(pop);

    always_ff @(posedge clock) begin
        if (reset || squash) credits_q <= '0;
        else                 credits_q <= credits_d;
    end

    assign busy = (credits_q != '0);

`ifndef SYNTHESIS
    localparam int SW = $clog2(STAGES + 1);
    // ops already inside the multiplier at a squash still raise mult_done
    // for up to STAGES cycles while their shadow valid is cleared
    logic [SW-1:0] sq_pend_q;

    always_ff @(posedge clock) begin
        if (reset)                  sq_pend_q <= '0;
        else if (squash)            sq_pend_q <= SW'(STAGES);
        else if (sq_pend_q != '0)   sq_pend_q <= sq_pend_q - SW'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset && !squash)
            assert (!(push && !pop && (count_q == CW'(OUT_DEPTH))));
        if (!reset && (sq_pend_q == '0))
            assert (mult_done == vld_pipe_q[STAGES]);
    end
`endif

endmodule

// File: tb/tb_mult_fu_ctrl.sv
// Bench for mult_fu_ctrl: directed vector table, hand-written corner
// sequences and a randomized phase, all cycle-checked against a queue-based
// reference model. A delay-line multiplier model drives mult_done/product.
module tb_mult_fu_ctrl;
    localparam int NR = 4, TW = 6, ST = 8, OD = 12;

    logic                      clock = 1'b0;
    logic                      reset, squash, cdb_grant;
    logic [NR-1:0]             req_valid, req_ready;
    logic [NR-1:0][63:0]       req_opa, req_opb;
    logic [NR-1:0][TW-1:0]     req_tag;
    logic                      mult_start, mult_done, cdb_valid, busy;
    logic [63:0]               mult_mcand, mult_mplier, mult_product, cdb_value;
    logic [TW-1:0]             cdb_tag;

    mult_fu_ctrl #(.NUM_REQ(NR), .TAG_W(TW), .STAGES(ST), .OUT_DEPTH(OD)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_opa(req_opa), .req_opb(req_opb),
        .req_tag(req_tag), .req_ready(req_ready), .squash(squash),
        .mult_start(mult_start), .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
        .mult_done(mult_done), .mult_product(mult_product),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_grant(cdb_grant), .busy(busy)
    );

    always #5 clock = ~clock;

    // multiplier: mult_done exactly ST cycles after mult_start
    logic [ST:1]  dl_v;
    logic [63:0]  dl_p [1:ST];
    always @(posedge clock) begin
        if (reset) dl_v <= '0;
        else       dl_v <= {dl_v[ST-1:1], mult_start};
        dl_p[1] <= mult_mcand * mult_mplier;
        for (int k = 2; k <= ST; k++) dl_p[k] <= dl_p[k-1];
    end
    assign mult_done    = dl_v[ST];
    assign mult_product = dl_p[ST];

    // ---------------- reference model ----------------
    typedef struct { logic [TW-1:0] tag; logic [63:0] val; int due; } ent_t;
    ent_t        infl[$];   // accepted, not yet in the FIFO
    ent_t        fq[$];     // output FIFO contents
    int          rr, credits, cyc;
    bit          exp_start, chk_en;
    logic [63:0] exp_a, exp_b;
    int          checks, fails;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] m_ready();
        logic [NR-1:0] r;
        r = '0;
        if (!squash && !reset && credits < OD)
            for (int k = 0; k < NR; k++)
                if (r == '0 && req_valid[(rr + k) % NR]) r[(rr + k) % NR] = 1'b1;
        return r;
    endfunction

    task automatic model_check();
        chk("ready", 64'(req_ready), 64'(m_ready()));
        chk("cdb_valid", 64'(cdb_valid), 64'(fq.size() != 0));
        if (fq.size() != 0) begin
            chk("cdb_tag", 64'(cdb_tag), 64'(fq[0].tag));
            chk("cdb_value", cdb_value, fq[0].val);
        end
        chk("busy", 64'(busy), 64'(credits != 0));
        chk("mult_start", 64'(mult_start), 64'(exp_start));
        chk("mcand", mult_mcand, exp_a);
        chk("mplier", mult_mplier, exp_b);
    endtask

    task automatic model_step();
        logic [NR-1:0] er;
        int g;
        bit pop;
        ent_t e;
        er  = m_ready();
        g   = -1;
        for (int k = 0; k < NR; k++) if (er[k] && req_valid[k]) g = k;
        pop = cdb_grant && (fq.size() != 0);
        if (reset) begin
            infl.delete(); fq.delete();
            credits = 0; rr = 0; exp_start = 0; exp_a = '0; exp_b = '0;
        end else if (squash) begin
            infl.delete(); fq.delete();
            credits = 0; exp_start = 0;
        end else begin
            if (pop) void'(fq.pop_front());
            while (infl.size() != 0 && infl[0].due == cyc) fq.push_back(infl.pop_front());
            exp_start = (g >= 0);
            if (g >= 0) begin
                e.tag = req_tag[g];
                e.val = req_opa[g] * req_opb[g];
                e.due = cyc + ST + 1;
                infl.push_back(e);
                rr    = (g + 1) % NR;
                exp_a = req_opa[g];
                exp_b = req_opb[g];
            end
            credits = credits + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
        end
    endtask

    // inputs are driven between posedge+1 and the negedge; checks at negedge
    task automatic tick();
        @(negedge clock);
        if (chk_en) model_check();
        model_step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; squash = 1'b0; cdb_grant = 1'b0; req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    // one op on an idle unit, checked for exact latency and value
    task automatic run_single(input int rq, input logic [63:0] a, input logic [63:0] b,
                              input logic [TW-1:0] tg, input logic [63:0] prod, input string nm);
        req_valid = '0; req_valid[rq] = 1'b1;
        req_opa[rq] = a; req_opb[rq] = b; req_tag[rq] = tg; cdb_grant = 1'b0;
        #1;
        chk({nm, "_ready"}, 64'(req_ready), 64'(1) << rq);
        tick();
        req_valid = '0;
        #1;
        chk({nm, "_start"}, 64'(mult_start), 64'd1);
        chk({nm, "_mcand"}, mult_mcand, a);
        chk({nm, "_mplier"}, mult_mplier, b);
        repeat (8) tick();
        chk({nm, "_early"}, 64'(cdb_valid), 64'd0);
        tick();
        chk({nm, "_valid"}, 64'(cdb_valid), 64'd1);
        chk({nm, "_tag"}, 64'(cdb_tag), 64'(tg));
        chk({nm, "_value"}, cdb_value, prod);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        chk({nm, "_busy_after"}, 64'(busy), 64'd0);
        chk({nm, "_empty_after"}, 64'(cdb_valid), 64'd0);
    endtask

    typedef struct { int rq; logic [63:0] a; logic [63:0] b; logic [TW-1:0] tag; logic [63:0] prod; } vec_t;
    vec_t         vt[5];
    logic [TW-1:0] outq[$];
    int           acc, a_cyc;

    initial begin
        vt[0] = '{0, 64'd3, 64'd5, 6'd7, 64'd15};
        vt[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd63, 64'hFFFF_FFFF_FFFF_FFFE};
        vt[2] = '{2, 64'h1_0000_0000, 64'h1_0000_0000, 6'd0, 64'd0};
        vt[3] = '{3, 64'h1234, 64'h10, 6'd21, 64'h12340};
        vt[4] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd42, 64'd1};

        checks = 0; fails = 0; cyc = 0; chk_en = 0;
        reset = 1'b1; squash = 1'b0; cdb_grant = 1'b0; req_valid = '0;
        req_opa = '0; req_opb = '0; req_tag = '0;
        tick(); tick();
        reset = 1'b0; chk_en = 1;
        #1;
        chk("rst_start", 64'(mult_start), 64'd0);
        chk("rst_mcand", mult_mcand, 64'd0);
        chk("rst_mplier", mult_mplier, 64'd0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        chk("rst_cdb_value", cdb_value, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 5; i++)
            run_single(vt[i].rq, vt[i].a, vt[i].b, vt[i].tag, vt[i].prod, $sformatf("vec%0d", i));

        // round robin with the CDB granting every cycle
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_tag[i] = TW'(10 + i); req_opa[i] = 64'(i + 2); req_opb[i] = 64'(100 + i);
        end
        req_valid = '1; cdb_grant = 1'b1; outq.delete();
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("rr_onehot", 64'($countones(req_ready)), 64'd1);
            for (int k = 0; k < NR; k++) if (req_ready[k]) chk("rr_grant", 64'(k), 64'(c % NR));
            if (cdb_valid) outq.push_back(cdb_tag);
            tick();
        end
        req_valid = '0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (cdb_valid) outq.push_back(cdb_tag);
            tick();
        end
        chk("rr_count", 64'(outq.size()), 64'd20);
        for (int i = 0; i < outq.size(); i++) chk("rr_order", 64'(outq[i]), 64'(10 + i % NR));

        // backpressure: the FIFO fills and issue stops at the credit limit
        do_reset();
        req_valid = 4'b0100; req_tag[2] = 6'd50; req_opa[2] = 64'd9; req_opb[2] = 64'd9;
        acc = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (req_ready[2]) acc++;
            tick();
        end
        chk("bp_accepts", 64'(acc), 64'd12);
        chk("bp_ready_full", 64'(req_ready), 64'd0);
        cdb_grant = 1'b1;
        #1;
        chk("bp_ready_pop_cycle", 64'(req_ready), 64'd0);
        tick();
        cdb_grant = 1'b0; acc = 0; a_cyc = -1;
        req_tag[2] = 6'd51; req_opa[2] = 64'd7;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (req_ready[2]) begin acc++; a_cyc = cyc; end
            tick();
        end
        chk("bp_one_more", 64'(acc), 64'd1);
        chk("bp_extra_cycle", 64'(a_cyc), 64'(cyc - 9));
        // the extra op lands in the FIFO this cycle while the head is popped
        req_valid = '0; cdb_grant = 1'b1;
        #1;
        chk("bp_pushpop_head", 64'(cdb_tag), 64'd50);
        tick();
        chk("bp_busy_after_pushpop", 64'(busy), 64'd1);
        outq.delete();
        for (int c = 0; c < 16; c++) begin
            #1;
            if (cdb_valid) outq.push_back(cdb_tag);
            tick();
        end
        chk("bp_drain_count", 64'(outq.size()), 64'd11);
        if (outq.size() == 11) chk("bp_drain_last", 64'(outq[10]), 64'd51);
        chk("bp_idle", 64'(busy), 64'd0);

        // squash mid-flight
        do_reset();
        req_valid = 4'b0001; req_opa[0] = 64'd4; req_opb[0] = 64'd4;
        for (int c = 0; c < 5; c++) begin
            req_tag[0] = TW'(20 + c);
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
        squash = 1'b1;
        tick();
        squash = 1'b0;
        chk("sq_busy", 64'(busy), 64'd0);
        chk("sq_start", 64'(mult_start), 64'd0);
        for (int c = 0; c < 15; c++) begin
            chk("sq_no_result", 64'(cdb_valid), 64'd0);
            tick();
        end
        run_single(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd33, 64'hFFFF_FFFF_FFFF_FFFE, "post_sq");

        // squash together with req_valid and cdb_grant
        do_reset();
        req_valid = 4'b0001; req_opa[0] = 64'd6; req_opb[0] = 64'd7; req_tag[0] = 6'd40;
        tick();
        req_valid = '0;
        repeat (9) tick();
        req_valid = 4'b0010; req_tag[1] = 6'd41;
        repeat (3) tick();
        squash = 1'b1; req_valid = '1; cdb_grant = 1'b1;
        #1;
        chk("sim_no_accept", 64'(req_ready), 64'd0);
        chk("sim_head_valid", 64'(cdb_valid), 64'd1);
        chk("sim_head_tag", 64'(cdb_tag), 64'd40);
        chk("sim_head_value", cdb_value, 64'd42);
        tick();
        squash = 1'b0; req_valid = '0; cdb_grant = 1'b0;
        chk("sim_busy", 64'(busy), 64'd0);
        chk("sim_empty", 64'(cdb_valid), 64'd0);
        chk("sim_start", 64'(mult_start), 64'd0);
        for (int c = 0; c < 14; c++) begin
            chk("sim_no_result", 64'(cdb_valid), 64'd0);
            tick();
        end

        // reset with six ops in flight
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_opa[i] = 64'(i + 1); req_opb[i] = 64'd3; req_tag[i] = TW'(60 + i);
        end
        req_valid = '1;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        chk("rm_no_accept", 64'(req_ready), 64'd0);
        tick();
        reset = 1'b0; req_valid = '0;
        chk("rm_start", 64'(mult_start), 64'd0);
        chk("rm_mcand", mult_mcand, 64'd0);
        chk("rm_mplier", mult_mplier, 64'd0);
        chk("rm_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rm_cdb_tag", 64'(cdb_tag), 64'd0);
        chk("rm_cdb_value", cdb_value, 64'd0);
        chk("rm_busy", 64'(busy), 64'd0);
        for (int c = 0; c < 12; c++) begin
            chk("rm_no_stale", 64'(cdb_valid), 64'd0);
            tick();
        end
        req_valid = '1;
        #1;
        chk("rm_rr_zero", 64'(req_ready), 64'd1);
        tick();
        req_valid = '0; cdb_grant = 1'b1;
        repeat (14) tick();

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                req_opa[i] = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1000));
                req_opb[i] = {$urandom, $urandom};
                req_tag[i] = TW'($urandom);
            end
            cdb_grant = ($urandom_range(0, 9) < 6);
            squash    = ($urandom_range(0, 99) < 2);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; squash = 1'b0; req_valid = '0; cdb_grant = 1'b1;
        repeat (24) tick();
        chk("final_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/mult_fu_ctrl.md
Name: mult_fu_ctrl

Overview:
- Controller and arbiter for the shared `MULT_STAGES`-deep pipelined 64-bit multiplier, which returns the low 64 bits of the product.
- Sits between NUM_REQ reservation-station requesters and the CDB.
- Round-robin arbitrates issue, tracks destination tags in a shadow pipeline aligned to the multiplier, and buffers results in an output FIFO until the CDB grants them.
- The multiplier has no stall input, so the controller holds issue credits that guarantee every in-flight result a FIFO slot.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- TAG_W, 6, destination tag width.
- STAGES, `MULT_STAGES (8), multiplier depth in cycles from mult_start to mult_done.
- OUT_DEPTH, 12, output FIFO entries; also the credit limit.

Ports:
- clock, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- req_valid, input, NUM_REQ, per-requester request.
- req_opa, input, NUM_REQ x 64, multiplicand per requester.
- req_opb, input, NUM_REQ x 64, multiplier per requester.
- req_tag, input, NUM_REQ x TAG_W, destination tag per requester.
- req_ready, output, NUM_REQ, one-hot grant (combinational); a request is accepted when req_valid[i] & req_ready[i].
- squash, input, 1, mispredict flush; kills all in-flight and buffered work.
- mult_start, output, 1, start pulse to the multiplier.
- mult_mcand, output, 64, operand A to the multiplier.
- mult_mplier, output, 64, operand B to the multiplier.
- mult_done, input, 1, multiplier done.
- mult_product, input, 64, multiplier low product.
- cdb_valid, output, 1, FIFO head valid.
- cdb_tag, output, TAG_W, FIFO head tag.
- cdb_value, output, 64, FIFO head product.
- cdb_grant, input, 1, CDB takes the head this cycle.
- busy, output, 1, credits_used != 0.

Behaviour:
- Reset values: mult_start=0, mult_mcand=0, mult_mplier=0, FIFO empty (cdb_valid=0, cdb_tag=0, cdb_value=0), all shadow valids=0, credits_used=0, rr_ptr=0, busy=0.
- credits_used counts in-flight ops (issue register plus shadow pipeline) plus FIFO occupancy; range 0..OUT_DEPTH.
- Arbitration: can_issue = !squash & !reset & (credits_used < OUT_DEPTH). A pop in the same cycle does not free a credit for that cycle.
  - If can_issue, req_ready is one-hot at the first valid requester searching upward from rr_ptr with wrap-around. Otherwise req_ready = 0.
  - req_ready never depends on cdb_grant.
- Accept at cycle t:
  - rr_ptr <= (granted index + 1) mod NUM_REQ.
  - At t+1, mult_start=1 with the granted operands on mult_mcand/mult_mplier, and the granted tag enters stage 0 of the shadow pipeline with valid=1.
  - mult_start=0 in cycles with no accept; operand registers then hold their last value.
- The shadow pipeline (valid, tag) is STAGES deep and advances every cycle. An entry leaving it coincides with mult_done.
- On exit with valid=1, {tag, mult_product} is pushed to the FIFO. mult_done is ignored as a qualifier; a mismatch between mult_done and shadow valid (no squash pending) is an assertion failure.
- Latency: accept at t -> cdb_valid at t+STAGES+2 if the FIFO is empty and not stalled. Throughput is 1 op/cycle sustained while the CDB grants every cycle.
- FIFO:
  - Circular, OUT_DEPTH entries, wrap-around pointers.
  - Pop when cdb_valid & cdb_grant.
  - Push and pop in the same cycle are both performed.
  - Overflow is impossible by construction; assert it.
  - cdb_grant while empty is ignored.
- credits_used next = credits_used + accept − pop.
- squash (synchronous):
  - Next cycle: shadow valids=0, FIFO empty, credits_used=0, mult_start=0.
  - No accept occurs in the squash cycle.
  - A pop coinciding with squash is still counted as delivered.
  - Results from the multiplier for squashed ops arrive with shadow valid=0 and are discarded.
  - rr_ptr is unchanged.
- reset mid-operation: same clearing as squash plus rr_ptr=0. The multiplier's own done chain is reset by the same reset.
- Product width: the low 64 bits are forwarded unchanged; the controller performs no arithmetic on data.

Test Plan:
- Single op: req 0 valid with opa=3, opb=5, tag=7 at t=0 -> mult_start at t=1; cdb_valid, cdb_tag=7, cdb_value=15 at t=10 (STAGES=8); busy drops after the grant.
- Round-robin fairness: all 4 requesters valid continuously with distinct tags and cdb_grant=1 -> grants 0,1,2,3,0,… and results come out on the CDB in the same tag order, one per cycle.
- Backpressure: cdb_grant=0, requester 2 valid continuously -> exactly 12 accepts, then req_ready=0. After granting 1 entry, exactly 1 more accept occurs. FIFO never overflows.
- Squash mid-flight: 5 ops accepted, squash 3 cycles later -> no cdb_valid ever for those tags; credits_used=0 and busy=0 the next cycle. A new op accepted after the squash returns correctly (e.g. 0xFFFFFFFFFFFFFFFF × 2 -> 0xFFFFFFFFFFFFFFFE).
- Simultaneous events: push and pop in the same cycle at full FIFO, and squash in the same cycle as req_valid and cdb_grant -> no accept during squash, the granted head counted delivered, occupancy consistent.
- Reset mid-stream with 6 ops in flight -> all outputs at reset values the next cycle, rr_ptr=0, no stale results afterwards.
